dcache_req_queue: RTL
=====================

// Module: dcache_req_queue
// PURPOSE
// Upstream request stage for the L1 data cache. Accepts CPU load/store requests over valid/ready and
// buffers them in a DEPTH-entry in-order queue. Splits each address into tag/set/offset and presents
// the queue head to the dcache controller/datapath. Returns one response per request over valid/ready.
// Misaligned accesses are rejected locally with an error response and never reach the cache.
// PARAMETERS
// XLEN       32                       data/address width
// LINE_SIZE  32                       bytes per cache line
// NUM_SETS   8                        cache sets
// OFS_SIZE   $clog2(LINE_SIZE)        offset bits
// SET_SIZE   $clog2(NUM_SETS)         set-index bits
// TAG_SIZE   XLEN-SET_SIZE-OFS_SIZE   tag bits
// DEPTH      2                        queue entries; must be a power of two and >=2
// PORTS
// clk                in   1                        clock
// reset              in   1                        asynchronous, active-high reset
// cpu_req_valid      in   1                        CPU request valid
// cpu_req_ready      out  1                        queue can accept a request
// cpu_req_address    in   XLEN                     byte address
// cpu_req_type       in   memory_operation_e       LOAD/STORE
// cpu_req_size       in   memory_operation_size_e  BYTE/HALF/WORD
// cpu_req_wdata      in   XLEN                     store data, LSB-aligned
// cpu_rsp_valid      out  1                        response valid
// cpu_rsp_ready      in   1                        CPU accepts response
// cpu_rsp_rdata      out  XLEN                     load data; 0 for stores and for errors
// cpu_rsp_error      out  1                        request was misaligned
// pipe_req_valid     out  1                        head presented to cache
// pipe_req_tag/set/ofs out TAG/SET/OFS_SIZE        head address fields {tag,set,ofs}
// pipe_req_type      out  memory_operation_e       head type
// pipe_req_size      out  memory_operation_size_e  head size
// pipe_word_to_store out  XLEN                     head store data
// pipe_fetched_word  in   XLEN                     cache read data, valid with cache_req_done
// cache_req_done     in   1                        controller pulse: presented head has completed
// BEHAVIOUR
// - Reset clears pointers, count, cpu_rsp_valid, cpu_rsp_rdata and cpu_rsp_error to 0; pipe_req_valid
//   is 0. A reset mid-operation drops all queued and in-flight requests; no response is issued for them.
// - Enqueue occurs on cpu_req_valid && cpu_req_ready.
//   - cpu_req_ready = (count < DEPTH), from registered state only; a same-cycle pop does not raise it.
//   - Each entry stores the address fields, type, size, wdata and a misaligned flag computed at enqueue.
//   - Misaligned: HALF with addr[0]=1, or WORD with addr[1:0]!=0. BYTE is never misaligned.
// - rsp_free = !cpu_rsp_valid || cpu_rsp_ready.
// - pipe_req_valid = (count!=0) && !head.misaligned && rsp_free.
//   - pipe_* fields mirror the head whenever count!=0, and are 0 when the queue is empty.
//   - The fields are stable from first presentation until cache_req_done.
// - Aligned head completion: cache_req_done && pipe_req_valid.
//   - Pops the head.
//   - Next edge: cpu_rsp_valid=1, error=0, rdata = (LOAD ? pipe_fetched_word : 0).
// - Misaligned head: when rsp_free, the head is popped in one cycle.
//   - Next edge: cpu_rsp_valid=1, error=1, rdata=0.
// - Response register is single-entry.
//   - Cleared on cpu_rsp_valid && cpu_rsp_ready unless refilled in the same cycle (refill wins).
// - Latency: request enqueued at edge N into an empty queue gives pipe_req_valid in cycle N+1.
//   - Done in that cycle gives cpu_rsp_valid after edge N+2.
// - Simultaneous enqueue and pop: count is unchanged and both pointers advance; legal at count==DEPTH.
// - Pointers are $clog2(DEPTH) bits and wrap naturally. count is $clog2(DEPTH)+1 bits.
// - cache_req_done while pipe_req_valid=0 is ignored; flag it with an assertion.
// - Responses are strictly in request order.
// STRUCTURE
// - xentry_pkg:
//   - memory_operation_e and memory_operation_size_e, already present.
//   - New function is_misaligned(size, addr[1:0]), shared with the icache.
// - Sub-module xentry_fifo #(WIDTH, DEPTH): async-reset circular buffer with push/pop/count/head,
//   instantiated once with the packed entry struct.
// - Response register and pipe_req_valid/pop logic are in this module.
// TESTING (LINE_SIZE=32, NUM_SETS=8, DEPTH=2)
// 1. LOAD WORD at 0x0000_0104; done 3 cycles after presentation with fetched 0xDEADBEEF
//    -> pipe tag=0x1, set=0, ofs=4 held stable; next cycle rsp_valid=1, rdata=0xDEADBEEF, error=0.
// 2. HALF LOAD at 0x0000_0003 -> pipe_req_valid never 1; rsp_valid=1, error=1, rdata=0, two cycles
//    after enqueue.
// 3. rsp_ready=0 and 3 stores issued -> 1st completes and fills rsp; 2nd/3rd fill queue;
//    pipe_req_valid=0 and cpu_req_ready=0. Then rsp_ready=1 -> responses drain in order.
// 4. 6 back-to-back STOREs with done every presented cycle and rsp_ready=1 -> 6 responses in order,
//    rdata=0; pointers wrap 3 times.
// 5. Reset pulsed while a head is presented and the response is pending -> pipe_req_valid, cpu_rsp_valid
//    fall without a clock edge; count=0 after release.
// 6. count=1, done on head and a new cpu_req in the same cycle -> count stays 1, new head presented
//    next cycle.

Source files
------------

// File: rtl/xentry_pkg.sv
// ============================================================================
//  Package     : xentry_pkg
//  Description : Memory-request enumerations and shared helpers for the L1
//                cache request stages.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package xentry_pkg;

   typedef enum logic {
      LOAD  = 1'b0,
      STORE = 1'b1
   } memory_operation_e;

   typedef enum logic [1:0] {
      BYTE = 2'd0,
      HALF = 2'd1,
      WORD = 2'd2
   } memory_operation_size_e;

   // An access is misaligned when its low address bits do not fit its size.
   function automatic logic is_misaligned(input memory_operation_size_e size,
                                          input logic [1:0] addr_lo);
      logic mis;
      mis = 1'b0;
      case (size)
         HALF:    mis = addr_lo[0];
         WORD:    mis = (addr_lo != 2'b00);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

`default_nettype wire

// File: rtl/xentry_fifo.sv
// ============================================================================
//  Module      : xentry_fifo
//  Description : Circular buffer of WIDTH-bit entries with push/pop, an
//                occupancy count and a combinational head view.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module xentry_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         push_data,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   // A pop frees a slot in the same cycle, so push is legal when full and popping.
   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count < FULL_COUNT) || do_pop);
   assign head    = mem[rd_ptr];

   // Storage array needs no reset: the head is only consumed when count != 0.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers wrap naturally; count tracks occupancy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/dcache_req_queue.sv
// ============================================================================
//  Module      : dcache_req_queue
//  Description : L1 data-cache request stage. Buffers CPU requests in order,
//                presents the head to the cache, rejects misaligned accesses
//                locally and returns one response per request.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_req_queue
   import xentry_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int LINE_SIZE = 32,
   parameter int NUM_SETS  = 8,
   parameter int OFS_SIZE  = $clog2(LINE_SIZE),
   parameter int SET_SIZE  = $clog2(NUM_SETS),
   parameter int TAG_SIZE  = XLEN - SET_SIZE - OFS_SIZE,
   parameter int DEPTH     = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cpu_req_valid,
   output logic                   cpu_req_ready,
   input  logic [XLEN-1:0]        cpu_req_address,
   input  memory_operation_e      cpu_req_type,
   input  memory_operation_size_e cpu_req_size,
   input  logic [XLEN-1:0]        cpu_req_wdata,
   output logic                   cpu_rsp_valid,
   input  logic                   cpu_rsp_ready,
   output logic [XLEN-1:0]        cpu_rsp_rdata,
   output logic                   cpu_rsp_error,
   output logic                   pipe_req_valid,
   output logic [TAG_SIZE-1:0]    pipe_req_tag,
   output logic [SET_SIZE-1:0]    pipe_req_set,
   output logic [OFS_SIZE-1:0]    pipe_req_ofs,
   output memory_operation_e      pipe_req_type,
   output memory_operation_size_e pipe_req_size,
   output logic [XLEN-1:0]        pipe_word_to_store,
   input  logic [XLEN-1:0]        pipe_fetched_word,
   input  logic                   cache_req_done
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

   typedef struct packed {
      logic [TAG_SIZE-1:0]    tag;
      logic [SET_SIZE-1:0]    set;
      logic [OFS_SIZE-1:0]    ofs;
      memory_operation_e      op;
      memory_operation_size_e size;
      logic [XLEN-1:0]        wdata;
      logic                   misaligned;
   } entry_t;

   localparam int ENTRY_W = $bits(entry_t);

   entry_t             new_entry;
   entry_t             head;
   logic [ENTRY_W-1:0] head_bits;
   logic [CNT_W-1:0]   count;
   logic               push;
   logic               pop;
   logic               head_valid;
   logic               rsp_free;
   logic               aligned_done;
   logic               misaligned_pop;

   // Address split and misalignment are resolved once, at enqueue.
   always_comb begin
      new_entry            = '0;
      new_entry.tag        = cpu_req_address[XLEN-1 -: TAG_SIZE];
      new_entry.set        = cpu_req_address[OFS_SIZE +: SET_SIZE];
      new_entry.ofs        = cpu_req_address[OFS_SIZE-1:0];
      new_entry.op         = cpu_req_type;
      new_entry.size       = cpu_req_size;
      new_entry.wdata      = cpu_req_wdata;
      new_entry.misaligned = is_misaligned(cpu_req_size, cpu_req_address[1:0]);
   end

   // Ready depends on registered occupancy only; a same-cycle pop does not raise it.
   assign cpu_req_ready  = (count < FULL_COUNT);
   assign push           = cpu_req_valid && cpu_req_ready;
   assign head           = entry_t'(head_bits);
   assign head_valid     = (count != '0);

   // A head may only retire when the response register can take its result.
   assign rsp_free       = !cpu_rsp_valid || cpu_rsp_ready;
   assign pipe_req_valid = head_valid && !head.misaligned && rsp_free;
   assign aligned_done   = cache_req_done && pipe_req_valid;
   assign misaligned_pop = head_valid && head.misaligned && rsp_free;
   assign pop            = aligned_done || misaligned_pop;

   xentry_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .push_data (new_entry),
      .head      (head_bits),
      .count     (count)
   );

   // Head fields mirror the queue head and read as zero when the queue is empty.
   always_comb begin
      pipe_req_tag       = '0;
      pipe_req_set       = '0;
      pipe_req_ofs       = '0;
      pipe_req_type      = LOAD;
      pipe_req_size      = BYTE;
      pipe_word_to_store = '0;
      if (head_valid) begin
         pipe_req_tag       = head.tag;
         pipe_req_set       = head.set;
         pipe_req_ofs       = head.ofs;
         pipe_req_type      = head.op;
         pipe_req_size      = head.size;
         pipe_word_to_store = head.wdata;
      end
   end

   // Single-entry response register; a refill takes priority over the drain.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cpu_rsp_valid <= 1'b0;
         cpu_rsp_rdata <= '0;
         cpu_rsp_error <= 1'b0;
      end else if (pop) begin
         cpu_rsp_valid <= 1'b1;
         cpu_rsp_error <= head.misaligned;
         cpu_rsp_rdata <= (!head.misaligned && (head.op == LOAD)) ? pipe_fetched_word : '0;
      end else if (cpu_rsp_valid && cpu_rsp_ready) begin
         cpu_rsp_valid <= 1'b0;
         cpu_rsp_rdata <= '0;
         cpu_rsp_error <= 1'b0;
      end
   end

   // The controller must only signal completion for a presented head.
   a_done_only_when_presented : assert property (
      @(posedge clk) disable iff (reset) cache_req_done |-> pipe_req_valid
   );

endmodule

`default_nettype wire
